// File: rtl/aska_spi_host_if.sv
// aska_spi_host_if: request handshake and SPI pins of aska_spi_host (master = requester, slave = host block)
interface aska_spi_host_if;
  logic        start;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic        busy;
  logic        done;
  logic        SPI_CS;
  logic        SPI_Clk;
  logic        SPI_MOSI;
  modport master(output start, addr, wdata, input ready, busy, done, SPI_CS, SPI_Clk, SPI_MOSI);
  modport slave(input start, addr, wdata, output ready, busy, done, SPI_CS, SPI_Clk, SPI_MOSI);
endinterface

// File: rtl/aska_spi_host.sv
// aska_spi_host: SPI mode-0 master sending 40-bit ASKA register-write frames (clk, resetn, bus); ASKA_SPI_HOST_QUEUE_EN adds a 2-entry request FIFO
module aska_spi_host #(
  parameter int CLK_DIV = 2
) (
  input logic           clk,
  input logic           resetn,
  aska_spi_host_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;
  localparam logic [7:0] PH = 8'(CLK_DIV - 1);
  state_t state;
  logic [7:0] phase;
  logic [5:0] bit_cnt;
  logic [38:0] sr;
  logic gap_half, busy_q, done_q, cs_q, sclk_q, mosi_q, launch;
  logic [33:0] req;
`ifdef ASKA_SPI_HOST_QUEUE_EN
  logic [33:0] fifo [2];
  logic [1:0] cnt;
  logic push, pop;
  always_comb begin
    pop = state == IDLE && cnt != 2'd0;
    launch = state == IDLE && (pop || bus.start);
    push = bus.start && !cnt[1] && !(state == IDLE && cnt == 2'd0);
    req = pop ? fifo[0] : {bus.addr, bus.wdata};
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= 2'd0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
      if (pop) fifo[0] <= fifo[1];
      if (push) fifo[cnt[0] & ~pop] <= {bus.addr, bus.wdata};
    end
  assign bus.ready = ~cnt[1];
`else
  assign launch = state == IDLE && bus.start;
  assign req = {bus.addr, bus.wdata};
  assign bus.ready = ~busy_q;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      phase <= 8'd0;
      bit_cnt <= 6'd0;
      sr <= '0;
      gap_half <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cs_q <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      phase <= phase - 8'd1;
      case (state)
        IDLE: begin
          phase <= PH;
          bit_cnt <= 6'd0;
          if (launch) begin
            state <= SETUP;
            sr <= {5'b00000, req};
            mosi_q <= 1'b1;
            cs_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        SETUP: if (phase == 8'd0) begin
          state <= LOW;
          phase <= PH;
        end
        LOW: if (phase == 8'd0) begin
          state <= HIGH;
          phase <= PH;
          sclk_q <= 1'b1;
        end
        HIGH: if (phase == 8'd0) begin
          phase <= PH;
          sclk_q <= 1'b0;
          if (bit_cnt == 6'd39) state <= HOLD;
          else begin
            state <= LOW;
            bit_cnt <= bit_cnt + 6'd1;
            sr <= {sr[37:0], 1'b0};
            mosi_q <= sr[38];
          end
        end
        HOLD: if (phase == 8'd0) begin
          state <= GAP;
          phase <= PH;
          cs_q <= 1'b1;
          gap_half <= 1'b0;
        end
        GAP: if (phase == 8'd0) begin
          phase <= PH;
          gap_half <= 1'b1;
          if (gap_half) begin
            state <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            mosi_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.SPI_CS = cs_q;
  assign bus.SPI_Clk = sclk_q;
  assign bus.SPI_MOSI = mosi_q;
endmodule

// File: tb/tb_aska_spi_host.sv
// tb_aska_spi_host: randomized self-checking bench for aska_spi_host against a frame-level reference model
`timescale 1ns/1ps
module tb_aska_spi_host;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic st = 1'b0;
  logic sel = 1'b0;
  logic [1:0] ad = 2'd0;
  logic [31:0] wd = 32'd0;
  logic o_cs, o_sclk, o_mosi, o_busy, o_done, o_ready;
  logic [39:0] got[$];
  int got_edges[$];
  int done_at[$];
  int falls[$];
  int cs_low, first_rise, cs_rise, min_gap, bad_mosi, busy_cyc;
  int checks = 0;
  int passes = 0;
  logic [31:0] regs [4];
  aska_spi_host_if ia();
  aska_spi_host_if ib();
  aska_spi_host #(.CLK_DIV(2)) dut_a(.clk(clk), .resetn(resetn), .bus(ia.slave));
  aska_spi_host #(.CLK_DIV(1)) dut_b(.clk(clk), .resetn(resetn), .bus(ib.slave));
  assign ia.start = st & ~sel;
  assign ia.addr = ad;
  assign ia.wdata = wd;
  assign ib.start = st & sel;
  assign ib.addr = ad;
  assign ib.wdata = wd;
  assign o_cs = sel ? ib.SPI_CS : ia.SPI_CS;
  assign o_sclk = sel ? ib.SPI_Clk : ia.SPI_Clk;
  assign o_mosi = sel ? ib.SPI_MOSI : ia.SPI_MOSI;
  assign o_busy = sel ? ib.busy : ia.busy;
  assign o_done = sel ? ib.done : ia.done;
  assign o_ready = sel ? ib.ready : ia.ready;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end
  task automatic send(input bit s, input logic [1:0] a, input logic [31:0] w);
    @(negedge clk);
    sel = s;
    ad = a;
    wd = w;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    ad = ~a;
    wd = ~w;
  endtask
  task automatic capture(input int ncyc, input int poke);
    logic [39:0] sh;
    logic pc, pk, pm;
    int ed, gap;
    got.delete();
    got_edges.delete();
    done_at.delete();
    falls.delete();
    cs_low = 0;
    first_rise = -1;
    cs_rise = -1;
    min_gap = 1000;
    bad_mosi = 0;
    busy_cyc = 0;
    sh = '0;
    ed = 0;
    gap = 0;
    pc = 1'b1;
    pk = 1'b0;
    pm = 1'b0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (!o_cs) cs_low++;
      if (o_busy) busy_cyc++;
      if (o_done) done_at.push_back(n);
      if (o_sclk && !pk) begin
        if (first_rise < 0) first_rise = n;
        sh = {sh[38:0], o_mosi};
        ed++;
      end
      if (!o_cs && !pc && o_mosi !== pm && !(pk && !o_sclk)) bad_mosi++;
      if (!o_cs && pc) begin
        falls.push_back(n);
        if (got.size() > 0 && gap < min_gap) min_gap = gap;
      end
      if (o_cs && !pc) begin
        got.push_back(sh);
        got_edges.push_back(ed);
        ed = 0;
        gap = 0;
        if (cs_rise < 0) cs_rise = n;
      end
      if (o_cs) gap++;
      pc = o_cs;
      pk = o_sclk;
      pm = o_mosi;
      if (n == poke) st = 1'b1;
      else if (n == poke + 1) st = 1'b0;
    end
  endtask
  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ia.SPI_CS, ia.SPI_Clk, ia.SPI_MOSI, ia.busy, ia.done, ia.ready} !== 6'b100001)
      $display("FAIL reset_a: got %b want 100001", {ia.SPI_CS, ia.SPI_Clk, ia.SPI_MOSI, ia.busy, ia.done, ia.ready});
    else passes++;
    checks++;
    if ({ib.SPI_CS, ib.SPI_Clk, ib.SPI_MOSI, ib.busy, ib.done, ib.ready} !== 6'b100001)
      $display("FAIL reset_b: got %b want 100001", {ib.SPI_CS, ib.SPI_Clk, ib.SPI_MOSI, ib.busy, ib.done, ib.ready});
    else passes++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_frame_div2;
    logic [39:0] exp;
    exp = {6'b100000, 2'd1, 32'hA5A5_0F0F};
    send(1'b0, 2'd1, 32'hA5A5_0F0F);
    capture(200, -1);
    checks++;
    if (got.size() != 1) $display("FAIL div2_frames: got %0d want 1", got.size()); else passes++;
    checks++;
    if ((got.size() > 0 ? got[0] : 40'hx) !== exp) $display("FAIL div2_data: got %h want %h", (got.size() > 0 ? got[0] : 40'hx), exp); else passes++;
    checks++;
    if ((got_edges.size() > 0 ? got_edges[0] : -1) != 40) $display("FAIL div2_edges: got %0d want 40", (got_edges.size() > 0 ? got_edges[0] : -1)); else passes++;
    checks++;
    if (cs_low != 82 * 2) $display("FAIL div2_cs_low: got %0d want %0d", cs_low, 82 * 2); else passes++;
    checks++;
    if (first_rise != 1 + 2 * 2) $display("FAIL div2_first_rise: got %0d want %0d", first_rise, 1 + 2 * 2); else passes++;
    checks++;
    if (cs_rise != 1 + 82 * 2) $display("FAIL div2_cs_rise: got %0d want %0d", cs_rise, 1 + 82 * 2); else passes++;
    checks++;
    if (done_at.size() != 1 || done_at[0] != 1 + 84 * 2) $display("FAIL div2_done: got %0d pulses first %0d want 1 at %0d", done_at.size(), (done_at.size() > 0 ? done_at[0] : -1), 1 + 84 * 2); else passes++;
    checks++;
    if (busy_cyc != 84 * 2) $display("FAIL div2_busy: got %0d want %0d", busy_cyc, 84 * 2); else passes++;
    checks++;
    if (bad_mosi != 0) $display("FAIL div2_mosi_timing: got %0d bad changes want 0", bad_mosi); else passes++;
  endtask
  task automatic test_frame_div1;
    logic [39:0] exp;
    exp = 40'h83_FFFF_FFFF;
    send(1'b1, 2'd3, 32'hFFFF_FFFF);
    capture(120, -1);
    checks++;
    if ((got.size() > 0 ? got[0] : 40'hx) !== exp) $display("FAIL div1_data: got %h want %h", (got.size() > 0 ? got[0] : 40'hx), exp); else passes++;
    checks++;
    if ((got_edges.size() > 0 ? got_edges[0] : -1) != 40) $display("FAIL div1_edges: got %0d want 40", (got_edges.size() > 0 ? got_edges[0] : -1)); else passes++;
    checks++;
    if (cs_low != 82 || first_rise != 3) $display("FAIL div1_timing: got cs_low %0d rise %0d want 82 3", cs_low, first_rise); else passes++;
    checks++;
    if (done_at.size() != 1 || done_at[0] != 85) $display("FAIL div1_done: got %0d pulses first %0d want 1 at 85", done_at.size(), (done_at.size() > 0 ? done_at[0] : -1)); else passes++;
    checks++;
    if (bad_mosi != 0) $display("FAIL div1_mosi_stable: got %0d bad changes want 0", bad_mosi); else passes++;
  endtask
  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      int d;
      logic [1:0] a;
      logic [31:0] w;
      logic [39:0] exp;
      d = (i % 2 == 1) ? 1 : 2;
      a = 2'($urandom);
      w = $urandom;
      exp = {6'b100000, a, w};
      send(i % 2 == 1, a, w);
      capture(84 * d + 20, -1);
      checks++;
      if ((got.size() > 0 ? got[0] : 40'hx) !== exp || got.size() != 1) $display("FAIL rand%0d_data: got %h want %h", i, (got.size() > 0 ? got[0] : 40'hx), exp); else passes++;
      checks++;
      if ((got_edges.size() > 0 ? got_edges[0] : -1) != 40) $display("FAIL rand%0d_edges: got %0d want 40", i, (got_edges.size() > 0 ? got_edges[0] : -1)); else passes++;
      checks++;
      if (done_at.size() != 1 || done_at[0] != 1 + 84 * d) $display("FAIL rand%0d_done: got %0d pulses first %0d want 1 at %0d", i, done_at.size(), (done_at.size() > 0 ? done_at[0] : -1), 1 + 84 * d); else passes++;
      checks++;
      if (cs_low != 82 * d) $display("FAIL rand%0d_cs_low: got %0d want %0d", i, cs_low, 82 * d); else passes++;
    end
  endtask
`ifdef ASKA_SPI_HOST_QUEUE_EN
  task automatic test_queue;
    logic [39:0] exp [4];
    int waited;
    for (int i = 0; i < 4; i++) exp[i] = {6'b100000, 2'(i), 32'($urandom)};
    @(negedge clk);
    sel = 1'b0;
    ad = exp[0][33:32];
    wd = exp[0][31:0];
    st = 1'b1;
    @(posedge clk);
    #1;
    fork
      capture(720, -1);
      begin
        ad = exp[1][33:32];
        wd = exp[1][31:0];
        @(posedge clk);
        #1;
        ad = exp[2][33:32];
        wd = exp[2][31:0];
        @(posedge clk);
        #1;
        ad = exp[3][33:32];
        wd = exp[3][31:0];
        checks++;
        if (o_ready !== 1'b0) $display("FAIL queue_full_ready: got %b want 0", o_ready); else passes++;
        waited = 0;
        while (o_ready !== 1'b1 && waited < 400) begin
          @(negedge clk);
          waited++;
        end
        @(posedge clk);
        #1;
        st = 1'b0;
        checks++;
        if (waited >= 400) $display("FAIL queue_ready_timeout: waited %0d cycles want < 400", waited); else passes++;
      end
    join
    checks++;
    if (got.size() != 4) $display("FAIL queue_frames: got %0d want 4", got.size()); else passes++;
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== exp[i] || got_edges[i] != 40) $display("FAIL queue_frame%0d: got %h/%0d edges want %h/40", i, got[i], got_edges[i], exp[i]); else passes++;
    end
    checks++;
    if (done_at.size() != 4) $display("FAIL queue_done: got %0d pulses want 4", done_at.size()); else passes++;
    checks++;
    if (min_gap < 4) $display("FAIL queue_gap: got %0d want >= 4", min_gap); else passes++;
    checks++;
    if (falls.size() < 2 || done_at.size() < 1 || falls[1] != done_at[0] + 1) $display("FAIL queue_next_setup: got %0d want %0d", (falls.size() > 1 ? falls[1] : -1), (done_at.size() > 0 ? done_at[0] + 1 : -1)); else passes++;
  endtask
`else
  task automatic test_ignore_start;
    logic [39:0] exp;
    logic [31:0] w;
    w = $urandom;
    exp = {6'b100000, 2'd2, w};
    send(1'b0, 2'd2, w);
    capture(360, 50);
    checks++;
    if (got.size() != 1 || got[0] !== exp) $display("FAIL ignore_frames: got %0d frames first %h want 1 %h", got.size(), (got.size() > 0 ? got[0] : 40'hx), exp); else passes++;
    checks++;
    if (done_at.size() != 1) $display("FAIL ignore_done: got %0d pulses want 1", done_at.size()); else passes++;
  endtask
`endif
  task automatic test_reset_mid;
    int ed;
    logic pk;
    logic [31:0] w;
    logic [39:0] exp;
    send(1'b0, 2'd2, 32'hDEAD_BEEF);
    ed = 0;
    pk = 1'b0;
    for (int n = 0; n < 300 && ed < 20; n++) begin
      @(negedge clk);
      if (o_sclk && !pk) ed++;
      pk = o_sclk;
    end
    checks++;
    if (ed != 20) $display("FAIL midreset_reach: got %0d edges want 20", ed); else passes++;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({o_cs, o_sclk, o_mosi, o_busy, o_ready} !== 5'b10001) $display("FAIL midreset_async: got %b want 10001", {o_cs, o_sclk, o_mosi, o_busy, o_ready}); else passes++;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    capture(200, -1);
    checks++;
    if (done_at.size() != 0 || got.size() != 0) $display("FAIL midreset_quiet: got %0d done %0d frames want 0 0", done_at.size(), got.size()); else passes++;
    w = $urandom;
    exp = {6'b100000, 2'd0, w};
    send(1'b0, 2'd0, w);
    capture(190, -1);
    checks++;
    if (got.size() != 1 || got[0] !== exp || done_at.size() != 1 || done_at[0] != 169) $display("FAIL midreset_recover: got %h done %0d want %h done 169", (got.size() > 0 ? got[0] : 40'hx), (done_at.size() > 0 ? done_at[0] : -1), exp); else passes++;
  endtask
  task automatic test_loopback;
    logic [1:0] a [2];
    logic [31:0] w [2];
    a[0] = 2'd0;
    w[0] = 32'h1234_5678;
    a[1] = 2'd3;
    w[1] = 32'h0000_0001;
    for (int r = 0; r < 4; r++) regs[r] = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      send(1'b1, a[i], w[i]);
      capture(100, -1);
      foreach (got[k]) if (got_edges[k] == 40 && got[k][39:34] == 6'b100000) regs[got[k][33:32]] = got[k][31:0];
      checks++;
      if (regs[a[i]] !== w[i] || done_at.size() != 1) $display("FAIL loopback%0d: got %h want %h", i, regs[a[i]], w[i]); else passes++;
    end
    checks++;
    if (regs[0] !== 32'h1234_5678) $display("FAIL loopback_keep: got %h want 12345678", regs[0]); else passes++;
  endtask
  initial begin
    test_reset;
    test_frame_div2;
    test_frame_div1;
    test_random;
`ifdef ASKA_SPI_HOST_QUEUE_EN
    test_queue;
`else
    test_ignore_start;
`endif
    test_reset_mid;
    test_loopback;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
